// File: rtl/step_ramp_gen.sv
// step_ramp_gen: trapezoidal step-rate generator feeding the phase sequencer.
// Accepts move commands (steps, direction, cruise select) on a valid/ready
// handshake and emits one-clock step strobes with accel/cruise/decel spacing.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_steps         steps to move
//   cmd_dir           direction, 1 = forward
//   cmd_speed_sel     one-hot cruise select (other values: no ramp)
//   abort             level, requests a ramped stop
//   step_pulse        one-clock step strobe
//   step_dir          direction latched at accept
//   busy              move in progress (ACCEL/CRUISE/DECEL)
//   done              one-clock end-of-move pulse
//   cur_period        current step interval in clk cycles
//   position          (STEP_RAMP_POS_EN only) signed step position
//
// Optional feature: define STEP_RAMP_POS_EN to add the position output.
module step_ramp_gen #(
    parameter int CNT_W        = 32,
    parameter int START_PERIOD = 700000,
    parameter int MIN_PERIOD   = 100000,
    parameter int RAMP_DEC     = 20000,
    parameter int STEP_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [3:0]        cmd_speed_sel,
    input  logic              abort,
    output logic              step_pulse,
    output logic              step_dir,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cur_period
`ifdef STEP_RAMP_POS_EN
    ,
    output logic [31:0]       position
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0]  P_START = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0]  P_DEC   = CNT_W'(RAMP_DEC);
    localparam logic [CNT_W-1:0]  P_SEL1  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  P_SEL3  = CNT_W'(3 * MIN_PERIOD);
    localparam logic [CNT_W-1:0]  P_SEL5  = CNT_W'(5 * MIN_PERIOD);
    localparam logic [CNT_W-1:0]  P_SEL7  = CNT_W'(7 * MIN_PERIOD);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [STEP_W-1:0] S_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0] S_ZERO  = '0;
    localparam logic [STEP_W-1:0] S_MAX   = '1;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [CNT_W-1:0]  per_n;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  target_n;
    logic [CNT_W-1:0]  sel_target;
    logic [CNT_W-1:0]  per_up;
    logic [CNT_W-1:0]  per_dn;
    logic [STEP_W-1:0] rem;
    logic [STEP_W-1:0] rem_n;
    logic [STEP_W-1:0] ramp;
    logic [STEP_W-1:0] ramp_n;
    logic              dir_n;
    logic              running;
    logic              step_hit;
    logic              at_floor;

    // Cruise interval chosen by the speed select.
    always_comb begin
        sel_target = P_START;
        case (cmd_speed_sel)
            4'b0001: sel_target = P_SEL1;
            4'b0010: sel_target = P_SEL3;
            4'b0100: sel_target = P_SEL5;
            4'b1000: sel_target = P_SEL7;
            default: sel_target = P_START;
        endcase
    end

    assign running  = (state == ACCEL) ||
                      (state == CRUISE) ||
                      (state == DECEL);
    assign step_hit = running && (cnt == cur_period - C_ONE);

    // Slow down by one ramp increment, clamped at the start interval.
    // Written as a headroom compare so the add can never wrap.
    assign per_up = (P_START - cur_period <= P_DEC) ?
                    P_START : cur_period + P_DEC;

    // cur_period - RAMP_DEC <= target, without forming the difference.
    assign at_floor = (cur_period <= target + P_DEC);
    assign per_dn   = cur_period - P_DEC;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        per_n    = cur_period;
        target_n = target;
        rem_n    = rem;
        ramp_n   = ramp;
        dir_n    = step_dir;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    rem_n    = cmd_steps;
                    dir_n    = cmd_dir;
                    ramp_n   = S_ZERO;
                    per_n    = P_START;
                    cnt_n    = '0;
                    target_n = sel_target;
                    if (cmd_steps == S_ZERO) begin
                        state_n = DONE;
                    end else if (sel_target >= P_START) begin
                        state_n = CRUISE;
                    end else begin
                        state_n = ACCEL;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                cnt_n = cnt + C_ONE;
                if (step_hit) begin
                    cnt_n = '0;
                    rem_n = rem - S_ONE;
                    if (state == ACCEL && ramp != S_MAX) begin
                        ramp_n = ramp + S_ONE;
                    end
                    // Remaining steps no more than those spent ramping
                    // up means it is time to ramp back down.
                    if (rem_n == S_ZERO) begin
                        state_n = DONE;
                    end else if (rem_n <= ramp_n) begin
                        state_n = DECEL;
                        per_n   = per_up;
                    end else if (state == ACCEL) begin
                        if (at_floor) begin
                            per_n   = target;
                            state_n = CRUISE;
                        end else begin
                            per_n = per_dn;
                        end
                    end
                end
                // Abort trims the move to a mirror of the ramp done so
                // far; applied on top of any step taken this cycle.
                if (abort &&
                    (state == ACCEL || state == CRUISE) &&
                    state_n != DONE) begin
                    if (ramp_n < rem_n) begin
                        rem_n = ramp_n;
                    end
                    state_n = (rem_n == S_ZERO) ? DONE : DECEL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_period <= P_START;
            target     <= P_START;
            rem        <= '0;
            ramp       <= '0;
            step_dir   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cur_period <= per_n;
            target     <= target_n;
            rem        <= rem_n;
            ramp       <= ramp_n;
            step_dir   <= dir_n;
        end
    end

`ifdef STEP_RAMP_POS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            position <= '0;
        end else if (step_hit) begin
            position <= step_dir ? position + 32'd1 : position - 32'd1;
        end
    end
`endif

    assign cmd_ready  = (state == IDLE);
    assign busy       = running;
    assign done       = (state == DONE);
    assign step_pulse = step_hit;

endmodule

// File: tb/tb_step_ramp_gen.sv
// tb_step_ramp_gen: directed and randomized moves against a schedule model.
// Model tracks the absolute cycle of the next expected step.
module tb_step_ramp_gen;

    localparam int SP = 10;
    localparam int MP = 4;
    localparam int RD = 2;
    localparam int CW = 32;
    localparam int SW = 16;

    localparam int M_IDLE   = 0;
    localparam int M_ACCEL  = 1;
    localparam int M_CRUISE = 2;
    localparam int M_DECEL  = 3;
    localparam int M_DONE   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic [3:0]    cmd_speed_sel = '0;
    logic          cmd_ready;
    logic          step_pulse;
    logic          step_dir;
    logic          busy;
    logic          done;
    logic [CW-1:0] cur_period;
`ifdef STEP_RAMP_POS_EN
    logic [31:0]   position;
    logic [31:0]   m_pos;
`endif

    always #5 clk = ~clk;

    step_ramp_gen #(
        .CNT_W(CW),
        .START_PERIOD(SP),
        .MIN_PERIOD(MP),
        .RAMP_DEC(RD),
        .STEP_W(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir),
        .cmd_speed_sel(cmd_speed_sel),
        .abort(abort),
        .step_pulse(step_pulse),
        .step_dir(step_dir),
        .busy(busy),
        .done(done),
        .cur_period(cur_period)
`ifdef STEP_RAMP_POS_EN
        ,
        .position(position)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: mode, remaining steps, ramp depth and the
    // absolute cycle in which the next step strobe is due.
    int m_mode, m_rem, m_ramp, m_per, m_tgt, m_next;
    bit m_dir;

    function automatic int tgt_of(input logic [3:0] s);
        case (s)
            4'b0001: return MP;
            4'b0010: return 3 * MP;
            4'b0100: return 5 * MP;
            4'b1000: return 7 * MP;
            default: return SP;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin : model
        int was;
        if (!reset) begin
            m_mode = M_IDLE; m_rem = 0; m_ramp = 0;
            m_per = SP; m_tgt = SP; m_next = -1; m_dir = 0;
`ifdef STEP_RAMP_POS_EN
            m_pos = 0;
`endif
        end else if (m_mode == M_IDLE) begin
            if (cmd_valid) begin
                m_rem = int'(cmd_steps); m_dir = cmd_dir; m_ramp = 0;
                m_per = SP; m_tgt = tgt_of(cmd_speed_sel);
                m_next = cyc + SP;
                if (m_rem == 0) m_mode = M_DONE;
                else if (m_tgt >= SP) m_mode = M_CRUISE;
                else m_mode = M_ACCEL;
            end
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end else begin
            was = m_mode;
            if (cyc == m_next) begin
                m_rem = m_rem - 1;
`ifdef STEP_RAMP_POS_EN
                m_pos = m_dir ? m_pos + 1 : m_pos - 1;
`endif
                if (was == M_ACCEL && m_ramp < 65535) m_ramp++;
                if (m_rem == 0) m_mode = M_DONE;
                else if (m_rem <= m_ramp) begin
                    m_mode = M_DECEL;
                    m_per = (m_per + RD > SP) ? SP : m_per + RD;
                end else if (was == M_ACCEL) begin
                    if (m_per - RD <= m_tgt) begin
                        m_per = m_tgt; m_mode = M_CRUISE;
                    end else m_per = m_per - RD;
                end
                m_next = cyc + m_per;
            end
            if (abort && (was == M_ACCEL || was == M_CRUISE) &&
                m_mode != M_DONE) begin
                if (m_ramp < m_rem) m_rem = m_ramp;
                m_mode = (m_rem == 0) ? M_DONE : M_DECEL;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic e_busy, e_pulse;
        if (chk_en) begin
            e_busy  = (m_mode == M_ACCEL || m_mode == M_CRUISE ||
                       m_mode == M_DECEL);
            e_pulse = e_busy && (cyc == m_next);
            n_chk++;
            if (cmd_ready === (m_mode == M_IDLE) && step_pulse === e_pulse &&
                step_dir === m_dir && busy === e_busy &&
                done === (m_mode == M_DONE) && cur_period === CW'(m_per))
                n_pass++;
            else
                $display("FAIL cycle %0d rdy/pls/dir/bsy/dn/per got %b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, cmd_ready, step_pulse, step_dir, busy, done,
                         cur_period, m_mode == M_IDLE, e_pulse, m_dir,
                         e_busy, m_mode == M_DONE, m_per);
`ifdef STEP_RAMP_POS_EN
            check("position", position, m_pos);
`endif
        end
    end

    int pulse_q[$];
    int iv[$];
    int exp_q[$];
    int acc_cyc, done_cyc;
    bit busy_seen;

    task automatic start_move(input int steps, input bit dir,
                              input logic [3:0] sel, input bit hold);
        int k;
        @(negedge clk);
        cmd_valid = 1; cmd_steps = SW'(steps);
        cmd_dir = dir; cmd_speed_sel = sel;
        for (k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
        if (!cmd_ready) check("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(negedge clk);
        if (!hold) cmd_valid = 0;
    endtask

    task automatic wait_done(input int ab_after, input bit rnd_ab);
        int cnt;
        bit pend, fin;
        cnt = 0; pend = 0; fin = 0; busy_seen = 0;
        done_cyc = -1; pulse_q.delete();
        for (int k = 0; k < 3000 && !fin; k++) begin
            abort = 0;
            if (pend) begin abort = 1; pend = 0; end
            else if (rnd_ab && $urandom_range(0, 29) == 0) abort = 1;
            if (busy) busy_seen = 1;
            if (step_pulse) begin
                pulse_q.push_back(cyc); cnt++;
                if (cnt == ab_after) pend = 1;
            end
            if (done) begin done_cyc = cyc; fin = 1; abort = 0; end
            else @(negedge clk);
        end
        if (!fin) check("done_timeout", 0, 1);
    endtask

    task automatic check_iv(input string name);
        iv.delete();
        foreach (pulse_q[i])
            iv.push_back(pulse_q[i] - (i == 0 ? acc_cyc : pulse_q[i-1]));
        check($sformatf("%s_count", name), iv.size(), exp_q.size());
        for (int i = 0; i < iv.size() && i < exp_q.size(); i++)
            check($sformatf("%s_iv%0d", name, i), iv[i], exp_q[i]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] sel;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulse", step_pulse, 0);
        check("rst_done", done, 0);
        check("rst_period", cur_period, SP);
        @(negedge clk);
        reset = 1;

        // Full trapezoid.
        start_move(10, 1, 4'b0001, 0);
        wait_done(0, 0);
        exp_q = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
        check_iv("t1");
        check("t1_done_lag", done_cyc - pulse_q[$], 1);
        check("t1_dir", step_dir, 1);
        @(negedge clk);
        check("t1_ready_after", cmd_ready, 1);

        // Triangle profile.
        start_move(4, 0, 4'b0001, 0);
        wait_done(0, 0);
        exp_q = '{10, 8, 10, 10};
        check_iv("t2");

        // Zero-step move.
        start_move(0, 1, 4'b0001, 0);
        wait_done(0, 0);
        check("t3_pulses", pulse_q.size(), 0);
        check("t3_done_at", done_cyc - acc_cyc, 1);
        check("t3_busy_seen", busy_seen, 0);

        // Abort during cruise after the fifth step.
        start_move(100, 1, 4'b0001, 0);
        wait_done(5, 0);
        check("t4_pulses", pulse_q.size(), 8);
        check("t4_done_lag", done_cyc - pulse_q[$], 1);

        // Non-one-hot select with valid held through the move.
        start_move(3, 1, 4'b0011, 1);
        wait_done(0, 0);
        exp_q = '{10, 10, 10};
        check_iv("t5");
        @(negedge clk);
        check("t5_ready_idle", cmd_ready, 1);
        @(negedge clk);
        check("t5_reaccept", busy, 1);
        cmd_valid = 0;
        acc_cyc = cyc - 1;
        wait_done(0, 0);

        // Reset in the middle of a move.
        start_move(20, 1, 4'b0001, 0);
        repeat (25) @(negedge clk);
        #2 reset = 0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_ready", cmd_ready, 1);
        check("mr_dir", step_dir, 0);
        check("mr_period", cur_period, SP);
        check("mr_done", done, 0);
`ifdef STEP_RAMP_POS_EN
        check("mr_position", position, 0);
`endif
        @(negedge clk);
        reset = 1;

`ifdef STEP_RAMP_POS_EN
        start_move(5, 1, 4'b0001, 0);
        wait_done(0, 0);
        check("t6_pos_a", position, 32'd5);
        start_move(7, 0, 4'b0010, 0);
        wait_done(0, 0);
        check("t6_pos_b", position, 32'hFFFF_FFFE);
`endif

        // Randomized moves with sporadic aborts.
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 4))
                0: sel = 4'b0001;
                1: sel = 4'b0010;
                2: sel = 4'b0100;
                3: sel = 4'b1000;
                default: sel = 4'($urandom_range(0, 15));
            endcase
            start_move($urandom_range(0, 14), 1'($urandom_range(0, 1)),
                       sel, 0);
            wait_done(0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
